data_mem_access_ctrl: RTL and testbench

//  MEM-stage load/store controller placed directly upstream of data_ram256x8. It accepts one

---
 rtl/data_mem_access_ctrl.sv | 258 +++++++++++++++++++++++++
 tb/tb_data_mem_access_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_access_ctrl
//
// MEM-stage load/store controller sitting directly in front of a byte-addressed
// RAM (data_ram256x8 style: Enable / ReadWrite / Address / DataIn / Size in,
// DataOut back). One pipeline request is accepted at a time over a valid/ready
// handshake. The request is checked for alignment, range and legal size at the
// accept edge. A legal request is then walked through a fixed access sequence:
//
//   IDLE -> SETUP -> ACCESS (ACCESS_CYCLES cycles) -> CAPTURE -> RESP -> IDLE
//
// A rejected request takes a one-cycle ERR response instead:
//
//   IDLE -> ERR -> IDLE
//
// Either path finishes with a one-cycle response pulse. That pulse carries
// zero- or sign-extended load data, or an error flag.
//
// Parameters
//   MEM_BYTES      addressable bytes in the RAM (highest legal address MEM_BYTES-1)
//   ACCESS_CYCLES  cycles MemEnable is held high per access (1..15)
//
// Ports
//   Clk           in   rising-edge clock
//   Reset         in   asynchronous, active-low reset
//   ReqValid      in   request present
//   ReqReady      out  controller idle and able to accept
//   ReqRW         in   0 = load, 1 = store
//   ReqAddr[31:0] in   byte address
//   ReqData[31:0] in   store data, right-justified
//   ReqSize[1:0]  in   00 byte, 01 half, 10 word, 11 illegal
//   ReqSigned     in   loads: 1 = sign-extend, 0 = zero-extend
//   RspValid      out  one-cycle response pulse
//   RspData[31:0] out  extended load data (0 for stores and errors)
//   RspErr        out  request was rejected
//   ErrCount[7:0] out  saturating count of rejected requests
//   MemEnable     out  RAM Enable
//   MemReadWrite  out  RAM ReadWrite
//   MemAddress    out  RAM Address
//   MemDataIn     out  RAM DataIn, masked to the access size
//   MemSize       out  RAM Size
//   MemDataOut    in   RAM DataOut (byte/half right-justified, upper bits ignored)
// -----------------------------------------------------------------------------
module data_mem_access_ctrl #(
  parameter int MEM_BYTES     = 256,
  parameter int ACCESS_CYCLES = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqRW,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqData,
  input  logic [1:0]  ReqSize,
  input  logic        ReqSigned,
  output logic        RspValid,
  output logic [31:0] RspData,
  output logic        RspErr,
  output logic [7:0]  ErrCount,
  output logic        MemEnable,
  output logic        MemReadWrite,
  output logic [31:0] MemAddress,
  output logic [31:0] MemDataIn,
  output logic [1:0]  MemSize,
  input  logic [31:0] MemDataOut
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic [3:0]  CNT_LOAD  = 4'(ACCESS_CYCLES - 1);
  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_ACCESS  = 3'd2,
    S_CAPTURE = 3'd3,
    S_RESP    = 3'd4,
    S_ERR     = 3'd5
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Latched request; also drives the RAM buses, which therefore hold their
  // last values while idle.
  logic        r_mem_rw;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_din;
  logic [1:0]  r_mem_size;
  logic        r_signed;

  logic [3:0]  r_cnt;
  logic [31:0] r_load_data;
  logic [7:0]  r_err_cnt;

  logic        w_accept;
  logic        w_req_err;
  logic [2:0]  w_nbytes;
  logic [32:0] w_last_byte;
  logic [31:0] w_store_masked;
  logic [31:0] w_load_ext;

  // ---------------------------------------------------------------------------
  // Request checking (combinational, evaluated on the live request inputs and
  // used only at the accept edge)
  // ---------------------------------------------------------------------------
  assign w_accept = ReqValid && (r_state == S_IDLE);

  always_comb begin
    w_nbytes = 3'd4;
    case (ReqSize)
      SZ_BYTE: w_nbytes = 3'd1;
      SZ_HALF: w_nbytes = 3'd2;
      default: w_nbytes = 3'd4;
    endcase
  end

  // 33-bit sum so an address near 2^32 cannot wrap back into range.
  assign w_last_byte = {1'b0, ReqAddr} + {30'd0, w_nbytes} - 33'd1;

  always_comb begin
    w_req_err = 1'b0;
    if (ReqSize == SZ_ILL)
      w_req_err = 1'b1;
    if ((ReqSize == SZ_HALF) && ReqAddr[0])
      w_req_err = 1'b1;
    if ((ReqSize == SZ_WORD) && (ReqAddr[1:0] != 2'b00))
      w_req_err = 1'b1;
    if (w_last_byte >= MEM_LIMIT)
      w_req_err = 1'b1;
  end

  always_comb begin
    w_store_masked = ReqData;
    case (ReqSize)
      SZ_BYTE: w_store_masked = {24'd0, ReqData[7:0]};
      SZ_HALF: w_store_masked = {16'd0, ReqData[15:0]};
      default: w_store_masked = ReqData;
    endcase
  end

  // Extension of the RAM read data; only the bits of the access size matter.
  always_comb begin
    w_load_ext = MemDataOut;
    case (r_mem_size)
      SZ_BYTE: w_load_ext = {{24{r_signed & MemDataOut[7]}},  MemDataOut[7:0]};
      SZ_HALF: w_load_ext = {{16{r_signed & MemDataOut[15]}}, MemDataOut[15:0]};
      default: w_load_ext = MemDataOut;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept)
          w_state_next = w_req_err ? S_ERR : S_SETUP;
      end
      S_SETUP:   w_state_next = S_ACCESS;
      S_ACCESS: begin
        if (r_cnt == 4'd0)
          w_state_next = S_CAPTURE;
      end
      S_CAPTURE: w_state_next = S_RESP;
      S_RESP:    w_state_next = S_IDLE;
      S_ERR:     w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. Decoded straight from the state, so an asynchronous reset
  // drops MemEnable and RspValid immediately.
  // ---------------------------------------------------------------------------
  always_comb begin
    ReqReady  = 1'b0;
    MemEnable = 1'b0;
    RspValid  = 1'b0;
    RspErr    = 1'b0;
    RspData   = 32'd0;
    case (r_state)
      S_IDLE:   ReqReady  = 1'b1;
      S_ACCESS: MemEnable = 1'b1;
      S_RESP: begin
        RspValid = 1'b1;
        RspData  = r_load_data;
      end
      S_ERR: begin
        RspValid = 1'b1;
        RspErr   = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_mem_rw    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_din   <= 32'd0;
      r_mem_size  <= 2'b00;
      r_signed    <= 1'b0;
      r_cnt       <= 4'd0;
      r_load_data <= 32'd0;
      r_err_cnt   <= 8'd0;
    end else begin
      // A rejected request never reaches the RAM, so the buses keep their
      // previous contents.
      if (w_accept && !w_req_err) begin
        r_mem_rw   <= ReqRW;
        r_mem_addr <= ReqAddr;
        r_mem_din  <= w_store_masked;
        r_mem_size <= ReqSize;
        r_signed   <= ReqSigned;
      end

      // Loaded one cycle before ACCESS so it counts the ACCESS cycles exactly.
      if (r_state == S_SETUP)
        r_cnt <= CNT_LOAD;
      else if ((r_state == S_ACCESS) && (r_cnt != 4'd0))
        r_cnt <= r_cnt - 4'd1;

      if (r_state == S_CAPTURE)
        r_load_data <= r_mem_rw ? 32'd0 : w_load_ext;

      if ((r_state == S_ERR) && (r_err_cnt != 8'hFF))
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign MemReadWrite = r_mem_rw;
  assign MemAddress   = r_mem_addr;
  assign MemDataIn    = r_mem_din;
  assign MemSize      = r_mem_size;
  assign ErrCount     = r_err_cnt;

endmodule

// File: tb/tb_data_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_mem_access_ctrl
//
// Two controllers are instantiated. Instance 0 uses ACCESS_CYCLES=1 and
// instance 1 uses ACCESS_CYCLES=3. Each drives its own behavioural byte RAM.
//
// The bench model describes every transaction by when things happen relative
// to the accept edge. It derives the expected response value from a shadow
// copy of memory contents. A single negedge process compares both DUTs against
// that model on every cycle. Directed transactions then pin selected results
// to hand-computed literals.
// -----------------------------------------------------------------------------
module tb_data_mem_access_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_rw    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_data  [2];
  logic [1:0]  req_size  [2];
  logic        req_signed[2];
  logic        rsp_valid [2];
  logic [31:0] rsp_data  [2];
  logic        rsp_err   [2];
  logic [7:0]  err_count [2];
  logic        mem_en    [2];
  logic        mem_rw    [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_din   [2];
  logic [1:0]  mem_size  [2];
  logic [31:0] mem_dout  [2];

  data_mem_access_ctrl #(.MEM_BYTES(256), .ACCESS_CYCLES(1)) u_dut0 (
    .Clk(clk), .Reset(rst_n),
    .ReqValid(req_valid[0]), .ReqReady(req_ready[0]), .ReqRW(req_rw[0]),
    .ReqAddr(req_addr[0]), .ReqData(req_data[0]), .ReqSize(req_size[0]),
    .ReqSigned(req_signed[0]), .RspValid(rsp_valid[0]), .RspData(rsp_data[0]),
    .RspErr(rsp_err[0]), .ErrCount(err_count[0]), .MemEnable(mem_en[0]),
    .MemReadWrite(mem_rw[0]), .MemAddress(mem_addr[0]), .MemDataIn(mem_din[0]),
    .MemSize(mem_size[0]), .MemDataOut(mem_dout[0])
  );

  data_mem_access_ctrl #(.MEM_BYTES(256), .ACCESS_CYCLES(3)) u_dut1 (
    .Clk(clk), .Reset(rst_n),
    .ReqValid(req_valid[1]), .ReqReady(req_ready[1]), .ReqRW(req_rw[1]),
    .ReqAddr(req_addr[1]), .ReqData(req_data[1]), .ReqSize(req_size[1]),
    .ReqSigned(req_signed[1]), .RspValid(rsp_valid[1]), .RspData(rsp_data[1]),
    .RspErr(rsp_err[1]), .ErrCount(err_count[1]), .MemEnable(mem_en[1]),
    .MemReadWrite(mem_rw[1]), .MemAddress(mem_addr[1]), .MemDataIn(mem_din[1]),
    .MemSize(mem_size[1]), .MemDataOut(mem_dout[1])
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    n_total++;
    if (got === want)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
  endtask

  function automatic int ac(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic int nbytes(logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural RAMs (big-endian), written through the DUT's pins
  // ---------------------------------------------------------------------------
  logic [7:0] ram [2][256];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_en[d] === 1'b1 && mem_rw[d] === 1'b1) begin
        for (int i = 0; i < nbytes(mem_size[d]); i++)
          ram[d][8'(mem_addr[d] + 32'(i))] <=
            8'(mem_din[d] >> (8 * (nbytes(mem_size[d]) - 1 - i)));
      end
    end
  end

  // Read data is presented well before the capture edge. Upper bits of
  // byte/half reads carry junk that the controller must ignore.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [31:0] v;
      v = 32'd0;
      for (int i = 0; i < nbytes(mem_size[d]); i++)
        v = (v << 8) | 32'(ram[d][8'(mem_addr[d] + 32'(i))]);
      if (mem_size[d] == 2'd0)      v = {24'hA5A5A5, v[7:0]};
      else if (mem_size[d] == 2'd1) v = {16'h5A5A, v[15:0]};
      mem_dout[d] <= v;
    end
  end

  // ---------------------------------------------------------------------------
  // Model: shadow memory plus per-transaction expectations
  // ---------------------------------------------------------------------------
  logic [7:0]  mm [2][256];
  bit          act    [2];
  bit          m_err  [2];
  int          k      [2];
  bit          e_rw   [2];
  logic [31:0] e_addr [2];
  logic [31:0] e_din  [2];
  logic [1:0]  e_size [2];
  logic [31:0] e_rsp  [2];
  int          err_m  [2];
  int          en_cnt [2];
  int          lat    [2];
  logic [31:0] got_rsp[2];
  logic [31:0] got_din[2];

  function automatic bit model_err(logic [31:0] a, logic [1:0] s);
    longint last;
    last = longint'(a) + longint'(nbytes(s)) - 1;
    return (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0) || (last >= 256);
  endfunction

  function automatic logic [31:0] model_read(int d, logic [31:0] a, logic [1:0] s, bit sg);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < nbytes(s); i++)
      v = (v << 8) | 32'(mm[d][8'(a + 32'(i))]);
    if (sg && s == 2'd0 && v[7])  v = v | 32'hFFFFFF00;
    if (sg && s == 2'd1 && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  function automatic logic [31:0] model_mask(logic [31:0] x, logic [1:0] s);
    if (s == 2'd0) return x & 32'h000000FF;
    if (s == 2'd1) return x & 32'h0000FFFF;
    return x;
  endfunction

  // ---------------------------------------------------------------------------
  // Per-cycle comparison against the model
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      string p;
      p = $sformatf("d%0d", d);
      if (act[d]) begin
        k[d]++;
        if (mem_en[d] === 1'b1) en_cnt[d]++;
        if (rsp_valid[d] === 1'b1) lat[d] = k[d];
        chk({p, " ready_busy"}, 32'(req_ready[d]), 32'd0);
        if (m_err[d]) begin
          chk({p, " err_valid"}, 32'(rsp_valid[d]), 32'd1);
          chk({p, " err_flag"},  32'(rsp_err[d]),   32'd1);
          chk({p, " err_data"},  rsp_data[d],       32'd0);
          chk({p, " err_men"},   32'(mem_en[d]),    32'd0);
          got_rsp[d] = rsp_data[d];
          if (err_m[d] < 255) err_m[d]++;
          act[d] = 1'b0;
        end else begin
          chk({p, " mem_en"}, 32'(mem_en[d]), 32'(k[d] >= 2 && k[d] <= 1 + ac(d)));
          chk({p, " rsp_valid"}, 32'(rsp_valid[d]), 32'(k[d] == 3 + ac(d)));
          if (k[d] <= 2 + ac(d)) begin
            chk({p, " mem_addr"}, mem_addr[d],      e_addr[d]);
            chk({p, " mem_size"}, 32'(mem_size[d]), 32'(e_size[d]));
            chk({p, " mem_rw"},   32'(mem_rw[d]),   32'(e_rw[d]));
            chk({p, " mem_din"},  mem_din[d],       e_din[d]);
            got_din[d] = mem_din[d];
          end
          if (k[d] == 3 + ac(d)) begin
            chk({p, " rsp_err"},  32'(rsp_err[d]), 32'd0);
            chk({p, " rsp_data"}, rsp_data[d],     e_rsp[d]);
            got_rsp[d] = rsp_data[d];
            act[d] = 1'b0;
          end
        end
      end else begin
        chk({p, " idle_ready"}, 32'(req_ready[d]), 32'd1);
        chk({p, " idle_valid"}, 32'(rsp_valid[d]), 32'd0);
        chk({p, " idle_men"},   32'(mem_en[d]),    32'd0);
        chk({p, " err_count"},  32'(err_count[d]), 32'(err_m[d]));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver: present a request, mark the accept edge in the model, scramble the
  // request inputs, optionally wait for the response.
  // ---------------------------------------------------------------------------
  task automatic send(int d, bit rw, logic [31:0] addr, logic [31:0] data,
                      logic [1:0] size, bit sg, bit wait_done);
    int t;
    req_rw[d] = rw; req_addr[d] = addr; req_data[d] = data;
    req_size[d] = size; req_signed[d] = sg; req_valid[d] = 1'b1;
    t = 0;
    while (req_ready[d] !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (req_ready[d] !== 1'b1) begin
      chk($sformatf("d%0d ready_timeout", d), 32'(req_ready[d]), 32'd1);
      req_valid[d] = 1'b0;
      return;
    end
    @(posedge clk);
    act[d] = 1'b1; k[d] = 0; en_cnt[d] = 0; lat[d] = 0;
    m_err[d] = model_err(addr, size);
    e_rw[d] = rw; e_addr[d] = addr; e_size[d] = size;
    e_din[d] = model_mask(data, size);
    e_rsp[d] = (rw || m_err[d]) ? 32'd0 : model_read(d, addr, size, sg);
    if (rw && !m_err[d])
      for (int i = 0; i < nbytes(size); i++)
        mm[d][8'(addr + 32'(i))] = 8'(data >> (8 * (nbytes(size) - 1 - i)));
    #1;
    req_valid[d] = 1'b0;
    req_rw[d] = 1'($urandom); req_addr[d] = $urandom; req_data[d] = $urandom;
    req_size[d] = 2'($urandom); req_signed[d] = 1'($urandom);
    if (wait_done) begin
      t = 0;
      while (act[d] && t < 40) begin
        @(negedge clk);
        t++;
      end
      if (act[d]) begin
        chk($sformatf("d%0d done_timeout", d), 32'(act[d]), 32'd0);
        act[d] = 1'b0;
      end
      $display("txn d%0d rw=%0d addr=%h size=%0d signed=%0d -> err=%0d rsp=%h lat=%0d",
               d, rw, addr, size, sg, m_err[d], got_rsp[d], lat[d]);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 256; i++) begin
        ram[d][i] = 8'd0;
        mm[d][i]  = 8'd0;
      end
      req_valid[d] = 1'b0; req_rw[d] = 1'b0; req_addr[d] = 32'd0;
      req_data[d] = 32'd0; req_size[d] = 2'd0; req_signed[d] = 1'b0;
      act[d] = 1'b0; err_m[d] = 0; k[d] = 0; en_cnt[d] = 0; lat[d] = 0;
      got_rsp[d] = 32'd0; got_din[d] = 32'd0;
    end
    ram[0][0] = 8'hB5;
    mm[0][0]  = 8'hB5;

    #3;
    chk("reset ready",    32'(req_ready[0]), 32'd1);
    chk("reset men",      32'(mem_en[0]),    32'd0);
    chk("reset rspvalid", 32'(rsp_valid[0]), 32'd0);
    chk("reset errcnt",   32'(err_count[0]), 32'd0);
    chk("reset memaddr",  mem_addr[0],       32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: unsigned byte load
    send(0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0, 1'b1);
    chk("t1 model",  e_rsp[0],        32'h000000B5);
    chk("t1 data",   got_rsp[0],      32'h000000B5);
    chk("t1 en_cyc", 32'(en_cnt[0]),  32'd1);
    chk("t1 lat",    32'(lat[0]),     32'd4);

    // 2: signed byte load
    send(0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b1, 1'b1);
    chk("t2 data", got_rsp[0], 32'hFFFFFFB5);

    // 3: half store then signed / unsigned half loads
    send(0, 1'b1, 32'd2, 32'h1234FFD3, 2'd1, 1'b0, 1'b1);
    chk("t3 din",  got_din[0], 32'h0000FFD3);
    chk("t3 rsp",  got_rsp[0], 32'h00000000);
    send(0, 1'b0, 32'd2, 32'd0, 2'd1, 1'b1, 1'b1);
    chk("t3 lds",  got_rsp[0], 32'hFFFFFFD3);
    send(0, 1'b0, 32'd2, 32'd0, 2'd1, 1'b0, 1'b1);
    chk("t3 ldu",  got_rsp[0], 32'h0000FFD3);

    // 4: rejected requests
    send(0, 1'b0, 32'd6,   32'd0, 2'd2, 1'b0, 1'b1);
    chk("t4 lat word6", 32'(lat[0]), 32'd1);
    send(0, 1'b1, 32'd3,   32'hFFFF, 2'd1, 1'b0, 1'b1);
    chk("t4 lat half3", 32'(lat[0]), 32'd1);
    send(0, 1'b0, 32'd0,   32'd0, 2'd3, 1'b0, 1'b1);
    chk("t4 lat size3", 32'(lat[0]), 32'd1);
    send(0, 1'b0, 32'd254, 32'd0, 2'd2, 1'b0, 1'b1);
    chk("t4 en_cyc", 32'(en_cnt[0]), 32'd0);
    @(negedge clk);
    chk("t4 errcnt", 32'(err_count[0]), 32'd4);

    // Range boundaries
    send(0, 1'b1, 32'd255, 32'h0000007E, 2'd0, 1'b0, 1'b1);
    send(0, 1'b0, 32'd255, 32'd0, 2'd0, 1'b1, 1'b1);
    chk("b byte255", got_rsp[0], 32'h0000007E);
    send(0, 1'b1, 32'd254, 32'hAAAABEEF, 2'd1, 1'b0, 1'b1);
    send(0, 1'b0, 32'd252, 32'd0, 2'd2, 1'b0, 1'b1);
    chk("b word252", got_rsp[0], 32'h0000BEEF);
    send(0, 1'b0, 32'd256, 32'd0, 2'd0, 1'b0, 1'b1);
    chk("b byte256 lat", 32'(lat[0]), 32'd1);
    send(0, 1'b0, 32'hFFFFFFFC, 32'd0, 2'd2, 1'b0, 1'b1);
    chk("b wrap lat", 32'(lat[0]), 32'd1);

    // 5: ACCESS_CYCLES=3
    send(1, 1'b1, 32'd8, 32'hE35D8AC5, 2'd2, 1'b0, 1'b1);
    chk("t5 en_cyc", 32'(en_cnt[1]), 32'd3);
    chk("t5 lat",    32'(lat[1]),    32'd6);
    chk("t5 din",    got_din[1],     32'hE35D8AC5);
    send(1, 1'b0, 32'd8, 32'd0, 2'd2, 1'b1, 1'b1);
    chk("t5 load",   got_rsp[1],     32'hE35D8AC5);

    // Error counter saturation
    for (int i = 0; i < 260; i++)
      send(1, 1'b0, 32'd1, 32'd0, 2'd1, 1'b0, 1'b1);
    @(negedge clk);
    chk("sat errcnt", 32'(err_count[1]), 32'd255);

    // 6: reset in the middle of ACCESS
    send(0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("t6 in_access", 32'(mem_en[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6 men_drop",   32'(mem_en[0]),    32'd0);
    chk("t6 valid_drop", 32'(rsp_valid[0]), 32'd0);
    chk("t6 ready",      32'(req_ready[0]), 32'd1);
    act[0] = 1'b0; act[1] = 1'b0; err_m[0] = 0; err_m[1] = 0;
    @(negedge clk);
    req_rw[0] = 1'b0; req_addr[0] = 32'd0; req_size[0] = 2'd0;
    req_signed[0] = 1'b0; req_valid[0] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    send(0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0, 1'b1);
    chk("t6 data", got_rsp[0],   32'h000000B5);
    chk("t6 lat",  32'(lat[0]),  32'd4);
    chk("t6 errcnt", 32'(err_count[1]), 32'd0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
